// File: rtl/axi_confreg_slave.sv
// axi_confreg_slave: AXI-style responder serving a bank of 32-bit config registers with burst reads.
// Optional macro RESP_DELAY_EN inserts DELAY wait cycles before the first read beat and the write response.
module axi_confreg_slave #(
   parameter int ADDR_W = 4,
   parameter int DELAY  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic        bvalid,
   input  logic        bready
);
   localparam int N = 2 ** ADDR_W;
   localparam logic [1:0] R_IDLE = 2'd0, R_DATA = 2'd2;
   localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd2, W_RESP = 2'd3;
`ifdef RESP_DELAY_EN
   localparam logic [1:0] R_WAIT = 2'd1, W_WAIT = 2'd1;
   logic [7:0] r_dly_q, r_dly_d, w_dly_q, w_dly_d;
`endif
   logic [1:0]        r_state_q, r_state_d, w_state_q, w_state_d;
   logic [ADDR_W-1:0] r_idx_q, r_idx_d, w_idx_q, w_idx_d, ar_idx, aw_idx;
   logic [7:0]        r_cnt_q, r_cnt_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       mem_q [N];
   logic              unused_ok;

   assign ar_idx    = araddr[ADDR_W+1:2];
   assign aw_idx    = awaddr[ADDR_W+1:2];
   assign unused_ok = ^{arsize, araddr[31:ADDR_W+2], araddr[1:0], awaddr[31:ADDR_W+2], awaddr[1:0]};

   always_comb begin
      r_state_d = r_state_q;
      r_idx_d   = r_idx_q;
      r_cnt_d   = r_cnt_q;
      rdata_d   = rdata_q;
`ifdef RESP_DELAY_EN
      r_dly_d   = r_dly_q;
`endif
      case (r_state_q)
         R_IDLE: if (arvalid) begin
            r_idx_d   = ar_idx;
            r_cnt_d   = arlen;
            rdata_d   = mem_q[ar_idx];
`ifdef RESP_DELAY_EN
            r_state_d = (DELAY == 0) ? R_DATA : R_WAIT;
            r_dly_d   = 8'(DELAY - 1);
`else
            r_state_d = R_DATA;
`endif
         end
`ifdef RESP_DELAY_EN
         R_WAIT: if (r_dly_q == '0) begin
            r_state_d = R_DATA;
            rdata_d   = mem_q[r_idx_q];
         end else begin
            r_dly_d = r_dly_q - 1'b1;
         end
`endif
         R_DATA: if (rready) begin
            if (r_cnt_q == '0) begin
               r_state_d = R_IDLE;
            end else begin
               r_idx_d = r_idx_q + 1'b1;
               r_cnt_d = r_cnt_q - 1'b1;
               rdata_d = mem_q[r_idx_d];
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      w_state_d = w_state_q;
      w_idx_d   = w_idx_q;
`ifdef RESP_DELAY_EN
      w_dly_d   = w_dly_q;
`endif
      case (w_state_q)
         W_IDLE: if (awvalid) begin
            w_idx_d   = aw_idx;
            w_state_d = W_DATA;
         end
         W_DATA: if (wvalid) begin
            w_idx_d = w_idx_q + 1'b1;
`ifdef RESP_DELAY_EN
            w_dly_d = 8'(DELAY - 1);
            if (wlast) w_state_d = (DELAY == 0) ? W_RESP : W_WAIT;
`else
            if (wlast) w_state_d = W_RESP;
`endif
         end
`ifdef RESP_DELAY_EN
         W_WAIT: if (w_dly_q == '0) w_state_d = W_RESP; else w_dly_d = w_dly_q - 1'b1;
`endif
         W_RESP: if (bready) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   // A write and a same-cycle read capture both sample the old mem_q, so the read sees pre-write data.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q <= R_IDLE;
         w_state_q <= W_IDLE;
         r_idx_q   <= '0;
         w_idx_q   <= '0;
         r_cnt_q   <= '0;
         rdata_q   <= '0;
`ifdef RESP_DELAY_EN
         r_dly_q   <= '0;
         w_dly_q   <= '0;
`endif
         for (int i = 0; i < N; i++) mem_q[i] <= '0;
      end else begin
         r_state_q <= r_state_d;
         w_state_q <= w_state_d;
         r_idx_q   <= r_idx_d;
         w_idx_q   <= w_idx_d;
         r_cnt_q   <= r_cnt_d;
         rdata_q   <= rdata_d;
`ifdef RESP_DELAY_EN
         r_dly_q   <= r_dly_d;
         w_dly_q   <= w_dly_d;
`endif
         if (w_state_q == W_DATA && wvalid)
            for (int b = 0; b < 4; b++)
               if (wstrb[b]) mem_q[w_idx_q][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   assign arready = ~rst & (r_state_q == R_IDLE);
   assign awready = ~rst & (w_state_q == W_IDLE);
   assign rvalid  = r_state_q == R_DATA;
   assign rlast   = rvalid & (r_cnt_q == '0);
   assign rdata   = rdata_q;
   assign wready  = w_state_q == W_DATA;
   assign bvalid  = w_state_q == W_RESP;
endmodule

// File: tb/tb_axi_confreg_slave.sv
// tb_axi_confreg_slave: randomized bench for axi_confreg_slave against an array model of the register bank.
// Latency expectations follow RESP_DELAY_EN (DELAY=2 when defined).
module tb_axi_confreg_slave;
   logic        clk = 0, rst = 1;
   logic [31:0] araddr = 0, awaddr = 0, wdata = 0, rdata;
   logic [7:0]  arlen = 0;
   logic [2:0]  arsize = 3'd2;
   logic [3:0]  wstrb = 0;
   logic        arvalid = 0, arready, rlast, rvalid, rready = 0;
   logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
   int          n_checks = 0, n_errors = 0;
   logic [31:0] ref_mem [16];
`ifdef RESP_DELAY_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif
   localparam int TMO = 50;

   axi_confreg_slave #(.ADDR_W(4), .DELAY(2)) dut (
      .clk(clk), .rst(rst),
      .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic sig(input int w);
      return w == 0 ? awready : w == 1 ? wready : w == 2 ? bvalid : w == 3 ? arready : rvalid;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_for(input int w, output int n);
      n = 0;
      while (!sig(w) && n < TMO) begin
         tick();
         n++;
      end
   endtask

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++)
         if (s[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit hold);
      int n;
      awaddr = a; awvalid = 1;
      wait_for(0, n);
      chk("aw_timeout", n < TMO, 1);
      tick();
      awvalid = 0;
      wdata = d; wstrb = s; wlast = 1; wvalid = 1;
      wait_for(1, n);
      chk("w_timeout", n < TMO, 1);
      tick();
      wvalid = 0; wlast = 0;
      model_write(a, d, s);
      wait_for(2, n);
      chk("b_latency", n + 1, LAT);
      if (!hold) begin
         repeat ($urandom_range(0, 3)) tick();
         chk("b_hold", bvalid, 1);
         bready = 1;
         tick();
         bready = 0;
         chk("b_drop", bvalid, 0);
      end
   endtask

   task automatic do_read(input logic [31:0] a, input logic [7:0] len, input int stall);
      int n;
      logic [3:0] idx;
      araddr = a; arlen = len; arvalid = 1;
      wait_for(3, n);
      chk("ar_timeout", n < TMO, 1);
      tick();
      arvalid = 0;
      wait_for(4, n);
      chk("r_latency", n + 1, LAT);
      idx = a[5:2];
      for (int k = 0; k <= int'(len); k++) begin
         int st;
         st = stall < 0 ? int'($urandom_range(0, 3)) : (k == 1 ? stall : 0);
         for (int s = 0; s < st; s++) begin
            rready = 0;
            tick();
            chk("r_stall_valid", rvalid, 1);
            chk("r_stall_data", rdata, ref_mem[idx]);
         end
         chk("rvalid", rvalid, 1);
         chk("rdata", rdata, ref_mem[idx]);
         chk("rlast", rlast, k == int'(len));
         rready = 1;
         tick();
         rready = 0;
         idx++;
      end
      chk("r_end", rvalid, 0);
   endtask

   initial begin
      int n;
      logic [31:0] old_v, new_v, a;
      for (int i = 0; i < 16; i++) ref_mem[i] = 0;
      repeat (2) tick();
      chk("rst_arready", arready, 0);
      chk("rst_awready", awready, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rdata", rdata, 0);
      rst = 0;
      tick();
      chk("idle_arready", arready, 1);
      chk("idle_awready", awready, 1);
      do_write(32'h08, 32'hDEADBEEF, 4'hF, 0);
      do_read(32'h08, 0, 0);
      do_write(32'h08, 32'h11223344, 4'b0101, 0);
      chk("partial_model", ref_mem[2], 32'hDE22BE44);
      do_read(32'h08, 0, 0);
      for (int i = 0; i < 16; i++) do_write(i * 4, i, 4'hF, 0);
      do_read(32'h38, 3, 0);
      do_read(32'h38, 3, 5);
      // Coincident W and AR handshakes on the same register.
      awaddr = 32'h0C; awvalid = 1;
      wait_for(0, n);
      tick();
      awvalid = 0;
      wdata = 32'hCAFEF00D; wstrb = 4'hF; wlast = 1; wvalid = 1;
      araddr = 32'h4C; arlen = 0; arvalid = 1;
      chk("coinc_ready", {wready, arready}, 2'b11);
      tick();
      wvalid = 0; wlast = 0; arvalid = 0;
      old_v = ref_mem[3];
      model_write(32'h0C, 32'hCAFEF00D, 4'hF);
      new_v = ref_mem[3];
      wait_for(4, n);
      chk("coinc_rdata", rdata, LAT == 1 ? old_v : new_v);
      chk("coinc_rlast", rlast, 1);
      rready = 1; bready = 1;
      tick();
      rready = 0; bready = 0;
      wait_for(2, n);
      if (bvalid) begin
         bready = 1;
         tick();
         bready = 0;
      end
      do_read(32'h0C, 0, 0);
      for (int t = 0; t < 30; t++) begin
         a = $urandom();
         if ($urandom_range(0, 1) == 1) do_write(a, $urandom(), 4'($urandom_range(0, 15)), 0);
         else do_read(a, 8'($urandom_range(0, 20)), -1);
      end
      do_write(32'h10, 32'h55AA55AA, 4'hF, 1);
      chk("pre_rst_bvalid", bvalid, 1);
      rst = 1;
      tick();
      rst = 0;
      #1;
      chk("post_rst_bvalid", bvalid, 0);
      chk("post_rst_awready", awready, 1);
      for (int i = 0; i < 16; i++) ref_mem[i] = 0;
      do_read(32'h00, 15, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
